// File: rtl/sram_arbiter_ctrl.sv
// Two-channel controller for one asynchronous SRAM: fixed-priority or
// round-robin arbitration, SETUP/ACCESS/HOLD strobe sequencing.
//
// Ports:
//   clk, rst (async, active low)
//   chN_req/we/addr/wdata  : channel N request (ch0 fetch, ch1 MEM stage)
//   chN_rdata/ack          : read data (held) and one-cycle completion pulse
//   busy                   : controller not idle
//   ram_en_n/oe_n/we_n     : active-low SRAM strobes
//   ram_addr, ram_data     : SRAM address and tri-state data bus
module sram_arbiter_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1,
    parameter int ROUND_ROBIN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ch0_req,
    input  logic              ch0_we,
    input  logic [ADDR_W-1:0] ch0_addr,
    input  logic [DATA_W-1:0] ch0_wdata,
    output logic [DATA_W-1:0] ch0_rdata,
    output logic              ch0_ack,
    input  logic              ch1_req,
    input  logic              ch1_we,
    input  logic [ADDR_W-1:0] ch1_addr,
    input  logic [DATA_W-1:0] ch1_wdata,
    output logic [DATA_W-1:0] ch1_rdata,
    output logic              ch1_ack,
    output logic              busy,
    output logic              ram_en_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("WAIT_CYCLES must be at least 1");
    end

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              gnt_q;
    logic              last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic pick;
    logic load;
    logic sample;
    logic data_oe;

    // 1 selects ch1. Round robin only matters when both ask at once.
    assign pick = (ch0_req && ch1_req)
                ? ((ROUND_ROBIN != 0) ? ~last_q : 1'b1)
                : ch1_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        sample   = 1'b0;
        data_oe  = 1'b0;
        busy     = 1'b1;
        ram_en_n = 1'b1;
        ram_oe_n = 1'b1;
        ram_we_n = 1'b1;
        ch0_ack  = 1'b0;
        ch1_ack  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (ch0_req || ch1_req) begin
                    load    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                ram_en_n = 1'b0;
                data_oe  = we_q;
                cnt_d    = CNT_INIT;
                state_d  = ACCESS;
            end
            ACCESS: begin
                ram_en_n = 1'b0;
                ram_oe_n = we_q;
                ram_we_n = ~we_q;
                data_oe  = we_q;
                if (cnt_q == '0) begin
                    sample  = ~we_q;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                // oe stays low on reads so the sampled word stays stable
                ram_en_n = 1'b0;
                ram_oe_n = we_q;
                data_oe  = we_q;
                ch0_ack  = ~gnt_q;
                ch1_ack  = gnt_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            gnt_q    <= 1'b0;
            last_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load) begin
                gnt_q   <= pick;
                last_q  <= pick;
                we_q    <= pick ? ch1_we : ch0_we;
                addr_q  <= pick ? ch1_addr : ch0_addr;
                wdata_q <= pick ? ch1_wdata : ch0_wdata;
            end
            if (sample) begin
                if (gnt_q) begin
                    rdata1_q <= ram_data;
                end else begin
                    rdata0_q <= ram_data;
                end
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_data  = data_oe ? wdata_q : {DATA_W{1'bz}};
    assign ch0_rdata = rdata0_q;
    assign ch1_rdata = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl: two instances (WAIT 1 fixed priority,
// WAIT 3 round robin), each with an SRAM model and a transaction model.
module tb_sram_arbiter_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic        r0 [2], r1 [2], w0 [2], w1 [2];
    logic [17:0] a0 [2], a1 [2], ra [2];
    logic [15:0] wd0 [2], wd1 [2], d0 [2], d1 [2];
    logic        k0 [2], k1 [2], bsy [2];
    logic        en_n [2], oe_n [2], we_n [2];

    function automatic void chk(string n, int g,
                                logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d actual=%0h required=%0h",
                     n, g, act, exp);
        end
    endfunction

    // initial SRAM contents, as a pure function of the low address byte
    function automatic logic [15:0] pre(logic [7:0] i);
        case (i)
            8'h10:   return 16'hBEEF;
            8'h20:   return 16'h5555;
            8'h30:   return 16'h3030;
            8'h60:   return 16'h6060;
            default: return {8'hC0, i};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_i
        localparam int W  = (g == 0) ? 1 : 3;
        localparam int RR = g;

        wire  [15:0] bus;
        logic [15:0] mem [256];
        bit          mw  [256];

        assign bus = (!en_n[g] && !oe_n[g] && we_n[g])
                   ? (mw[ra[g][7:0]] ? mem[ra[g][7:0]] : pre(ra[g][7:0]))
                   : 'z;

        always @(negedge clk) begin
            if (!en_n[g] && !we_n[g]) begin
                mem[ra[g][7:0]] <= bus;
                mw[ra[g][7:0]]  <= 1'b1;
            end
        end

        sram_arbiter_ctrl #(
            .DATA_W(16), .ADDR_W(18),
            .WAIT_CYCLES(W), .ROUND_ROBIN(RR)
        ) u_dut (
            .clk(clk), .rst(rst),
            .ch0_req(r0[g]), .ch0_we(w0[g]), .ch0_addr(a0[g]),
            .ch0_wdata(wd0[g]), .ch0_rdata(d0[g]), .ch0_ack(k0[g]),
            .ch1_req(r1[g]), .ch1_we(w1[g]), .ch1_addr(a1[g]),
            .ch1_wdata(wd1[g]), .ch1_rdata(d1[g]), .ch1_ack(k1[g]),
            .busy(bsy[g]), .ram_en_n(en_n[g]), .ram_oe_n(oe_n[g]),
            .ram_we_n(we_n[g]), .ram_addr(ra[g]), .ram_data(bus)
        );

        // Transaction model: m_t counts cycles since the accepting edge.
        // 0 = setup, 1..W = access, W+1 = hold, then one idle cycle.
        logic        m_busy, m_ch, m_we, m_last, c;
        int          m_t;
        logic [17:0] m_addr;
        logic [15:0] m_wdata, m_rd0, m_rd1;
        logic [15:0] shd [256];
        bit          sw  [256];

        always_comb begin
            c = r1[g];
            if (r0[g] && r1[g]) c = (RR != 0) ? !m_last : 1'b1;
        end

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                m_busy <= 0; m_t <= 0; m_ch <= 0; m_we <= 0;
                m_last <= 0; m_addr <= 0; m_wdata <= 0;
                m_rd0 <= 0; m_rd1 <= 0;
            end else if (!m_busy) begin
                if (r0[g] || r1[g]) begin
                    m_busy  <= 1; m_t <= 0;
                    m_ch    <= c; m_last <= c;
                    m_we    <= c ? w1[g] : w0[g];
                    m_addr  <= c ? a1[g] : a0[g];
                    m_wdata <= c ? wd1[g] : wd0[g];
                end
            end else begin
                if (m_t == W + 1) m_busy <= 0;
                else m_t <= m_t + 1;
                if (m_t == W) begin
                    if (m_we) begin
                        shd[m_addr[7:0]] <= m_wdata;
                        sw[m_addr[7:0]]  <= 1'b1;
                    end else if (m_ch) begin
                        m_rd1 <= sw[m_addr[7:0]] ? shd[m_addr[7:0]]
                                                 : pre(m_addr[7:0]);
                    end else begin
                        m_rd0 <= sw[m_addr[7:0]] ? shd[m_addr[7:0]]
                                                 : pre(m_addr[7:0]);
                    end
                end
            end
        end

        always @(negedge clk) begin
            chk("busy", g, bsy[g], m_busy);
            chk("en_n", g, en_n[g], !m_busy);
            chk("oe_n", g, oe_n[g], !(m_busy && !m_we && m_t >= 1));
            chk("we_n", g, we_n[g],
                !(m_busy && m_we && m_t >= 1 && m_t <= W));
            chk("addr", g, ra[g], m_addr);
            chk("ack0", g, k0[g], m_busy && m_t == W + 1 && !m_ch);
            chk("ack1", g, k1[g], m_busy && m_t == W + 1 && m_ch);
            chk("rdata0", g, d0[g], m_rd0);
            chk("rdata1", g, d1[g], m_rd1);
            chk("drive", g, u_dut.data_oe, m_busy && m_we);
            if (m_busy && m_we) chk("wbus", g, bus, m_wdata);
        end

        int n_ack0 = 0;
        int n_ack1 = 0;
        int n_wel  = 0;
        int log [$];
        always @(negedge clk) begin
            if (k0[g]) n_ack0 <= n_ack0 + 1;
            if (k1[g]) n_ack1 <= n_ack1 + 1;
            if (!we_n[g]) n_wel <= n_wel + 1;
            if (k0[g] || k1[g]) log.push_back(k1[g] ? 1 : 0);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rq(int g, int ch, logic we,
                      logic [17:0] a, logic [15:0] d);
        if (ch != 0) begin
            r1[g] = 1; w1[g] = we; a1[g] = a; wd1[g] = d;
        end else begin
            r0[g] = 1; w0[g] = we; a0[g] = a; wd0[g] = d;
        end
    endtask

    task automatic drop(int g, int ch);
        if (ch != 0) r1[g] = 0;
        else r0[g] = 0;
    endtask

    task automatic wait_ack(int g, int ch, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if ((ch != 0) ? k1[g] : k0[g]) begin
                at = cyc;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL ack_timeout inst%0d ch%0d actual=none required=ack",
                 g, ch);
    endtask

    int acc, at, at0, at1, base, na;
    int exp4 [4] = '{1, 0, 1, 0};

    initial begin
        for (int i = 0; i < 2; i++) begin
            r0[i] = 0; r1[i] = 0; w0[i] = 0; w1[i] = 0;
            a0[i] = 0; a1[i] = 0; wd0[i] = 0; wd1[i] = 0;
        end
        #1 rst = 0;
        tick(3);
        chk("rst_busy", 0, bsy[0], 0);
        chk("rst_en_n", 1, en_n[1], 1);
        chk("rst_oe_n", 0, oe_n[0], 1);
        chk("rst_we_n", 1, we_n[1], 1);
        chk("rst_addr", 0, ra[0], 0);
        chk("rst_rdata", 1, d1[1], 0);
        chk("rst_ack", 0, k0[0], 0);
        rst = 1;
        tick(2);

        // single read, WAIT 1
        rq(0, 0, 0, 18'h00010, 0);
        tick(1); acc = cyc; drop(0, 0);
        wait_ack(0, 0, at);
        chk("t1_latency", 0, at - acc, 2);
        chk("t1_rdata", 0, d0[0], 16'hBEEF);
        tick(2);

        // contention, fixed priority
        base = g_i[0].n_ack0;
        rq(0, 0, 0, 18'h00020, 0);
        rq(0, 1, 0, 18'h00030, 0);
        wait_ack(0, 1, at1); drop(0, 1);
        chk("t3_no_ack0_first", 0, g_i[0].n_ack0 - base, 0);
        wait_ack(0, 0, at0); drop(0, 0);
        chk("t3_gap", 0, at0 - at1, 4);
        chk("t3_rdata1", 0, d1[0], 16'h3030);
        chk("t3_rdata0", 0, d0[0], 16'h5555);
        tick(2);

        // back-to-back write then read, ch1
        rq(0, 1, 1, 18'h00040, 16'hA5A5);
        tick(1); drop(0, 1);
        wait_ack(0, 1, at);
        rq(0, 1, 0, 18'h00040, 0);
        wait_ack(0, 1, at); drop(0, 1);
        chk("t6_rdata", 0, d1[0], 16'hA5A5);
        chk("t6_mem", 0, g_i[0].mem[8'h40], 16'hA5A5);
        tick(2);

        // single write, WAIT 3
        base = g_i[1].n_wel;
        rq(1, 1, 1, 18'h3FFFF, 16'h1234);
        tick(1); acc = cyc; drop(1, 1);
        wait_ack(1, 1, at);
        chk("t2_latency", 1, at - acc, 4);
        tick(1);
        chk("t2_we_cycles", 1, g_i[1].n_wel - base, 3);
        chk("t2_mem", 1, g_i[1].mem[8'hFF], 16'h1234);
        tick(2);

        // reset in the middle of a write
        na = g_i[1].n_ack1;
        rq(1, 1, 1, 18'h00050, 16'h7777);
        tick(1); drop(1, 1);
        tick(1);
        chk("t5_we_active", 1, we_n[1], 0);
        #1 rst = 0;
        #1;
        chk("t5_en_n", 1, en_n[1], 1);
        chk("t5_we_n", 1, we_n[1], 1);
        chk("t5_oe_n", 1, oe_n[1], 1);
        chk("t5_busy", 1, bsy[1], 0);
        chk("t5_drive", 1, g_i[1].u_dut.data_oe, 0);
        tick(1);
        rst = 1;
        tick(5);
        chk("t5_no_ack", 1, g_i[1].n_ack1 - na, 0);
        rq(1, 0, 0, 18'h3FFFF, 0);
        tick(1); acc = cyc; drop(1, 0);
        wait_ack(1, 0, at);
        chk("t5_latency", 1, at - acc, 4);
        chk("t5_rdata", 1, d0[1], 16'h1234);
        tick(2);

        // contention, round robin, four accesses
        base = g_i[1].log.size();
        rq(1, 0, 0, 18'h3FFFF, 0);
        rq(1, 1, 0, 18'h00060, 0);
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (g_i[1].log.size() >= base + 4) break;
        end
        drop(1, 0); drop(1, 1);
        if (g_i[1].log.size() < base + 4) begin
            checks++;
            failures++;
            $display("FAIL t4_count actual=%0d required=4",
                     g_i[1].log.size() - base);
        end else begin
            for (int i = 0; i < 4; i++)
                chk("t4_order", 1, g_i[1].log[base + i], exp4[i]);
        end
        chk("t4_rdata1", 1, d1[1], 16'h6060);
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
